// File: rtl/cacheline_burst_adapter.sv
// Splits whole-line read/write requests from the cache core into fixed-length
// beat bursts towards memory, and reassembles read beats into a full line.
module cacheline_burst_adapter #(
    parameter int s_line  = 256,
    parameter int s_burst = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               line_read,
    input  logic               line_write,
    input  logic [31:0]        line_address,
    input  logic [s_line-1:0]  line_wdata,
    output logic [s_line-1:0]  line_rdata,
    output logic               line_resp,
    output logic               burst_read,
    output logic               burst_write,
    output logic [31:0]        burst_address,
    output logic [s_burst-1:0] burst_wdata,
    input  logic [s_burst-1:0] burst_rdata,
    input  logic               burst_resp
);

    localparam int NumBursts = s_line / s_burst;
    localparam int CntW      = $clog2(NumBursts);
    localparam int BeatShift = $clog2(s_burst);
    localparam logic [CntW-1:0] LastBeat = CntW'(NumBursts - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [s_line-1:0]  wdata_q, wdata_d;
    logic [s_line-1:0]  rdata_q, rdata_d;
    logic [CntW+BeatShift-1:0] beatBase;

    // Bit offset of the current beat; beats are ascending from bit 0.
    assign beatBase = {cnt_q, {BeatShift{1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Write-back wins over a simultaneous read; the held read is taken on the next IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (line_write) begin
                    addr_d  = line_address & 32'hFFFF_FFE0;
                    wdata_d = line_wdata;
                    cnt_d   = '0;
                    state_d = WRITE;
                end else if (line_read) begin
                    addr_d  = line_address & 32'hFFFF_FFE0;
                    cnt_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                if (burst_resp) begin
                    rdata_d[beatBase +: s_burst] = burst_rdata;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == LastBeat) begin
                        state_d = DONE;
                    end
                end
            end
            WRITE: begin
                if (burst_resp) begin
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == LastBeat) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs come from state alone, so reset drops them immediately.
    assign burst_read    = (state_q == READ);
    assign burst_write   = (state_q == WRITE);
    assign line_resp     = (state_q == DONE);
    assign burst_address = addr_q;
    assign burst_wdata   = wdata_q[beatBase +: s_burst];
    assign line_rdata    = rdata_q;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Self-checking bench for cacheline_burst_adapter: a behavioural memory supplies
// read beats and records write beats, and each scenario checks its own results.
module tb_cacheline_burst_adapter;

    localparam int SL = 256;
    localparam int SB = 64;
    localparam int NB = SL / SB;
    localparam logic [31:0] AddrMask = 32'hFFFF_FFE0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          line_read = 1'b0;
    logic          line_write = 1'b0;
    logic [31:0]   line_address = '0;
    logic [SL-1:0] line_wdata = '0;
    logic [SL-1:0] line_rdata;
    logic          line_resp;
    logic          burst_read;
    logic          burst_write;
    logic [31:0]   burst_address;
    logic [SB-1:0] burst_wdata;
    logic [SB-1:0] burst_rdata = '0;
    logic          burst_resp = 1'b0;

    int total = 0;
    int bad = 0;

    // Memory model state and observations recorded by driveTransfer.
    logic [SL-1:0] memLine;
    logic [31:0]   obsAddr[$];
    logic [SB-1:0] obsWBeats[$];
    logic [SB-1:0] obsHeld[$];
    int            respEdges[$];
    bit            burstKinds[$];
    int            edgesTaken;
    bit            timedOut;

    cacheline_burst_adapter #(.s_line(SL), .s_burst(SB)) dut (
        .clk(clk), .rst_n(rst_n),
        .line_read(line_read), .line_write(line_write),
        .line_address(line_address), .line_wdata(line_wdata),
        .line_rdata(line_rdata), .line_resp(line_resp),
        .burst_read(burst_read), .burst_write(burst_write),
        .burst_address(burst_address), .burst_wdata(burst_wdata),
        .burst_rdata(burst_rdata), .burst_resp(burst_resp)
    );

    always #5 clk = ~clk;

    function automatic logic [SL-1:0] randLine();
        logic [SL-1:0] v;
        v = '0;
        for (int i = 0; i < SL / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [SB-1:0] beatOf(input logic [SL-1:0] l, input int i);
        return SB'(l >> (i * SB));
    endfunction

    // Plays the cache core and the memory: issues a request, answers beats
    // (optionally pausing before beat gapBeat), and records what it sees.
    task automatic driveTransfer(input bit rd, input bit wr, input logic [31:0] addr,
                                 input logic [SL-1:0] wline, input int gapBeat,
                                 input int gapLen, input int dropAfter, input int wantResps);
        int beat;
        int gapCnt;
        int nResp;
        bit inBurst;
        beat = 0; gapCnt = 0; nResp = 0; inBurst = 0; edgesTaken = 0;
        obsAddr.delete(); obsWBeats.delete(); obsHeld.delete();
        respEdges.delete(); burstKinds.delete();
        @(negedge clk);
        line_read = rd; line_write = wr; line_address = addr; line_wdata = wline;
        while (nResp < wantResps && edgesTaken < 200) begin
            @(posedge clk);
            edgesTaken++;
            @(negedge clk);
            if (edgesTaken == 1 && wantResps == 1) begin
                line_address = $urandom;
                line_wdata = randLine();
            end
            burst_resp = 1'b0;
            burst_rdata = SB'({$urandom, $urandom, $urandom, $urandom});
            if (line_resp) begin
                respEdges.push_back(edgesTaken);
                nResp++;
                inBurst = 0;
                if (line_write) line_write = 1'b0;
                else line_read = 1'b0;
            end else if (burst_read || burst_write) begin
                if (!inBurst) begin
                    inBurst = 1; beat = 0; gapCnt = 0;
                    burstKinds.push_back(burst_write);
                    obsAddr.push_back(burst_address);
                end
                if (beat == gapBeat && gapCnt < gapLen) begin
                    gapCnt++;
                    if (burst_write) obsHeld.push_back(burst_wdata);
                end else begin
                    burst_resp = 1'b1;
                    if (burst_write) obsWBeats.push_back(burst_wdata);
                    else burst_rdata = beatOf(memLine, beat);
                    beat++;
                    if (burst_read && beat == dropAfter) line_read = 1'b0;
                end
            end
        end
        timedOut = (nResp < wantResps);
        line_read = 1'b0; line_write = 1'b0; burst_resp = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++; if (line_resp !== 1'b0) begin bad++; $display("[TB] FAIL reset_line_resp: got %b want 0", line_resp); end
        total++; if (burst_read !== 1'b0) begin bad++; $display("[TB] FAIL reset_burst_read: got %b want 0", burst_read); end
        total++; if (burst_write !== 1'b0) begin bad++; $display("[TB] FAIL reset_burst_write: got %b want 0", burst_write); end
        total++; if (line_rdata !== '0) begin bad++; $display("[TB] FAIL reset_line_rdata: got %0h want 0", line_rdata); end
        total++; if (burst_address !== 32'h0) begin bad++; $display("[TB] FAIL reset_address: got %0h want 0", burst_address); end
        total++; if (burst_wdata !== '0) begin bad++; $display("[TB] FAIL reset_wdata: got %0h want 0", burst_wdata); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read();
        for (int i = 0; i < NB; i++) memLine[i*SB +: SB] = {(SB/8){8'((i + 1) * 17)}};
        driveTransfer(1'b1, 1'b0, 32'h0000_1060, '0, -1, 0, -1, 1);
        total++; if (timedOut) begin bad++; $display("[TB] FAIL read_timeout: got no line_resp want line_resp"); end
        total++; if (edgesTaken + 1 != NB + 2) begin bad++; $display("[TB] FAIL read_latency: got %0d want %0d", edgesTaken + 1, NB + 2); end
        total++; if ((obsAddr.size() > 0 ? obsAddr[0] : 32'hx) !== 32'h0000_1060) begin bad++; $display("[TB] FAIL read_address: got %0h want 1060", obsAddr.size() > 0 ? obsAddr[0] : 32'hx); end
        total++; if (line_rdata !== memLine) begin bad++; $display("[TB] FAIL read_data: got %0h want %0h", line_rdata, memLine); end
        @(negedge clk);
        total++; if (line_resp !== 1'b0) begin bad++; $display("[TB] FAIL read_resp_width: got %b want 0", line_resp); end
    endtask

    task automatic test_write();
        logic [SL-1:0] wline;
        for (int i = 0; i < NB; i++) wline[i*SB +: SB] = {(SB/32){32'hDEAD_BEEF}} + SB'(i);
        driveTransfer(1'b0, 1'b1, 32'h0000_207F, wline, NB / 2, 2, -1, 1);
        total++; if (timedOut) begin bad++; $display("[TB] FAIL write_timeout: got no line_resp want line_resp"); end
        total++; if (edgesTaken + 1 != NB + 4) begin bad++; $display("[TB] FAIL write_latency: got %0d want %0d", edgesTaken + 1, NB + 4); end
        total++; if ((obsAddr.size() > 0 ? obsAddr[0] : 32'hx) !== 32'h0000_2060) begin bad++; $display("[TB] FAIL write_address: got %0h want 2060", obsAddr.size() > 0 ? obsAddr[0] : 32'hx); end
        total++; if (obsWBeats.size() != NB) begin bad++; $display("[TB] FAIL write_beat_count: got %0d want %0d", obsWBeats.size(), NB); end
        for (int i = 0; i < obsWBeats.size(); i++) begin
            total++; if (obsWBeats[i] !== beatOf(wline, i)) begin bad++; $display("[TB] FAIL write_beat%0d: got %0h want %0h", i, obsWBeats[i], beatOf(wline, i)); end
        end
        total++; if (obsHeld.size() != 2) begin bad++; $display("[TB] FAIL write_hold_count: got %0d want 2", obsHeld.size()); end
        for (int i = 0; i < obsHeld.size(); i++) begin
            total++; if (obsHeld[i] !== beatOf(wline, NB / 2)) begin bad++; $display("[TB] FAIL write_hold%0d: got %0h want %0h", i, obsHeld[i], beatOf(wline, NB / 2)); end
        end
        @(negedge clk);
        total++; if (line_resp !== 1'b0) begin bad++; $display("[TB] FAIL write_resp_width: got %b want 0", line_resp); end
    endtask

    task automatic test_simultaneous();
        logic [SL-1:0] wline;
        logic [31:0] addr;
        wline = randLine();
        memLine = randLine();
        addr = $urandom;
        driveTransfer(1'b1, 1'b1, addr, wline, -1, 0, -1, 2);
        total++; if (timedOut) begin bad++; $display("[TB] FAIL both_timeout: got %0d resps want 2", respEdges.size()); end
        total++; if (burstKinds.size() != 2 || burstKinds[0] != 1'b1 || burstKinds[1] != 1'b0) begin bad++; $display("[TB] FAIL both_order: got %0d bursts want write then read", burstKinds.size()); end
        total++; if (respEdges.size() == 2 && respEdges[1] - respEdges[0] != NB + 2) begin bad++; $display("[TB] FAIL both_gap: got %0d want %0d", respEdges[1] - respEdges[0], NB + 2); end
        total++; if (edgesTaken + 1 != 2 * (NB + 2)) begin bad++; $display("[TB] FAIL both_latency: got %0d want %0d", edgesTaken + 1, 2 * (NB + 2)); end
        total++; if (obsAddr.size() != 2 || obsAddr[1] !== (addr & AddrMask)) begin bad++; $display("[TB] FAIL both_read_address: got %0d addrs want %0h", obsAddr.size(), addr & AddrMask); end
        for (int i = 0; i < obsWBeats.size(); i++) begin
            total++; if (obsWBeats[i] !== beatOf(wline, i)) begin bad++; $display("[TB] FAIL both_wbeat%0d: got %0h want %0h", i, obsWBeats[i], beatOf(wline, i)); end
        end
        total++; if (line_rdata !== memLine) begin bad++; $display("[TB] FAIL both_read_data: got %0h want %0h", line_rdata, memLine); end
        @(negedge clk);
    endtask

    task automatic test_spurious_and_drop();
        logic [SL-1:0] prevLine;
        prevLine = memLine;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            burst_resp = 1'b1;
            burst_rdata = SB'({$urandom, $urandom, $urandom, $urandom});
        end
        @(negedge clk);
        total++; if (burst_read !== 1'b0 || burst_write !== 1'b0) begin bad++; $display("[TB] FAIL spurious_request: got %b%b want 00", burst_read, burst_write); end
        total++; if (line_rdata !== prevLine) begin bad++; $display("[TB] FAIL spurious_rdata: got %0h want %0h", line_rdata, prevLine); end
        burst_resp = 1'b0;
        memLine = randLine();
        driveTransfer(1'b1, 1'b0, $urandom, '0, -1, 0, 1, 1);
        total++; if (timedOut) begin bad++; $display("[TB] FAIL drop_timeout: got no line_resp want line_resp"); end
        total++; if (edgesTaken + 1 != NB + 2) begin bad++; $display("[TB] FAIL drop_latency: got %0d want %0d", edgesTaken + 1, NB + 2); end
        total++; if (line_rdata !== memLine) begin bad++; $display("[TB] FAIL drop_data: got %0h want %0h", line_rdata, memLine); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        int beat;
        bit reached;
        bit sawResp;
        logic [31:0] addr;
        beat = 0; reached = 0; sawResp = 0;
        memLine = randLine();
        @(negedge clk);
        line_read = 1'b1;
        line_address = $urandom;
        for (int c = 0; c < 40 && !reached; c++) begin
            @(posedge clk);
            @(negedge clk);
            burst_resp = 1'b0;
            if (burst_read) begin
                burst_resp = 1'b1;
                burst_rdata = beatOf(memLine, beat);
                if (beat == NB / 2) reached = 1;
                else beat++;
            end
        end
        total++; if (!reached) begin bad++; $display("[TB] FAIL midreset_reach: got beat %0d want beat %0d", beat, NB / 2); end
        rst_n = 1'b0;
        #1;
        total++; if (burst_read !== 1'b0) begin bad++; $display("[TB] FAIL midreset_burst_read: got %b want 0", burst_read); end
        line_read = 1'b0;
        burst_resp = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (line_resp !== 1'b0) sawResp = 1;
        end
        total++; if (sawResp) begin bad++; $display("[TB] FAIL midreset_line_resp: got 1 want 0"); end
        total++; if (line_rdata !== '0) begin bad++; $display("[TB] FAIL midreset_rdata: got %0h want 0", line_rdata); end
        rst_n = 1'b1;
        @(negedge clk);
        memLine = randLine();
        addr = $urandom;
        driveTransfer(1'b1, 1'b0, addr, '0, -1, 0, -1, 1);
        total++; if (timedOut || edgesTaken + 1 != NB + 2) begin bad++; $display("[TB] FAIL postreset_latency: got %0d want %0d", edgesTaken + 1, NB + 2); end
        total++; if (line_rdata !== memLine) begin bad++; $display("[TB] FAIL postreset_data: got %0h want %0h", line_rdata, memLine); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int kind;
        int gapBeat;
        int gapLen;
        int wantEdges;
        logic [SL-1:0] wline;
        logic [31:0] addr;
        for (int it = 0; it < 8; it++) begin
            kind = $urandom_range(0, 2);
            gapBeat = $urandom_range(0, NB - 1);
            gapLen = $urandom_range(0, 3);
            wline = randLine();
            memLine = randLine();
            addr = $urandom;
            driveTransfer(kind != 1, kind != 0, addr, wline, gapBeat, gapLen, -1, kind == 2 ? 2 : 1);
            wantEdges = (kind == 2) ? 2 * (NB + 2 + gapLen) : NB + 2 + gapLen;
            total++; if (timedOut || edgesTaken + 1 != wantEdges) begin bad++; $display("[TB] FAIL rand%0d_latency: got %0d want %0d", it, edgesTaken + 1, wantEdges); end
            total++; if (obsAddr.size() == 0 || obsAddr[0] !== (addr & AddrMask)) begin bad++; $display("[TB] FAIL rand%0d_address: got %0d addrs want %0h", it, obsAddr.size(), addr & AddrMask); end
            if (kind != 0) begin
                total++; if (obsWBeats.size() != NB) begin bad++; $display("[TB] FAIL rand%0d_wcount: got %0d want %0d", it, obsWBeats.size(), NB); end
                for (int i = 0; i < obsWBeats.size(); i++) begin
                    total++; if (obsWBeats[i] !== beatOf(wline, i)) begin bad++; $display("[TB] FAIL rand%0d_wbeat%0d: got %0h want %0h", it, i, obsWBeats[i], beatOf(wline, i)); end
                end
            end
            if (kind != 1) begin
                total++; if (line_rdata !== memLine) begin bad++; $display("[TB] FAIL rand%0d_rdata: got %0h want %0h", it, line_rdata, memLine); end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_simultaneous();
        test_spurious_and_drop();
        test_reset_mid_burst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cacheline_burst_adapter.md
# cacheline_burst_adapter

Converts the pipelined cache core's whole-line downstream requests (256-bit read/write, single request/response) into fixed-length beat bursts on the physical memory port, and back. Sits directly below the cache core's downstream interface, between it and main memory. Its line-side ports connect one-to-one to the core's downstream ports; its burst side drives the memory model.

## Interface
Parameters:
- s_line, 256, cache line width in bits
- s_burst, 64, memory beat width in bits; num_bursts = s_line/s_burst (4 by default), power of two ≥ 2

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- line_read  in  1  line read request from cache core, held until line_resp
- line_write  in  1  line write-back request from cache core, held until line_resp
- line_address  in  32  line address; bits [4:0] ignored
- line_wdata  in  s_line  write-back line data
- line_rdata  out  s_line  assembled read line
- line_resp  out  1  one-cycle completion pulse
- burst_read  out  1  memory read request
- burst_write  out  1  memory write request
- burst_address  out  32  latched line address, bits [4:0] forced to 0
- burst_wdata  out  s_burst  current write beat
- burst_rdata  in  s_burst  current read beat
- burst_resp  in  1  memory beat acknowledge, one per beat

## Operation
- States: IDLE, READ, WRITE, DONE. Beat counter cnt, log2(num_bursts) bits.
- IDLE: if line_write → latch address and line_wdata, cnt=0, go WRITE. Else if line_read → latch address, cnt=0, go READ. Both high: write served first; read remains pending and is accepted in the next IDLE cycle.
- READ: burst_read=1. Each cycle with burst_resp=1: store burst_rdata into line_rdata[cnt*s_burst +: s_burst], cnt++. On the beat where cnt==num_bursts-1 → DONE.
- WRITE: burst_write=1, burst_wdata = latched line[cnt*s_burst +: s_burst]. Each burst_resp advances cnt. Last beat → DONE.
- DONE: line_resp=1 for exactly this cycle, burst_read=burst_write=0. Go IDLE unconditionally. Requests are not accepted in DONE.
- Beats need not be consecutive; cycles with burst_resp=0 hold cnt and keep the request asserted.
- Beat order is fixed: beat 0 = bits [s_burst-1:0], ascending.
- Once accepted, a transfer always completes. Dropping line_read/line_write mid-transfer is ignored. line_address/line_wdata changes after acceptance are ignored.
- burst_resp in IDLE or DONE is ignored; it does not alter cnt or line_rdata.
- cnt wraps to 0 at completion. Overflow is not possible.
- line_rdata holds the last assembled line until the next read beat overwrites it. Valid no later than the DONE cycle.

## Timing
- Reset (async assert, rising-edge sync deassert): state IDLE, cnt 0, line_rdata 0, latched address/data 0. Outputs line_resp, burst_read, burst_write are 0 immediately on reset assertion.
- burst_read, burst_write and line_resp are decoded from state only; there is no combinational path from line_* or burst_resp.
- Request seen in cycle 0 → burst_* asserted in cycle 1.
- With memory responding on cycles k..k+num_bursts-1, line_resp is high in cycle k+num_bursts.
- Minimum latency, request to line_resp: num_bursts+2 cycles (6 by default).
- Back-to-back: write-back then read (cache miss on a dirty line) costs 2×(num_bursts+2) cycles minimum, with one IDLE cycle between.
- Reset asserted mid-burst: transfer is abandoned, and the next request restarts at beat 0.

## Test plan
- Read 0x0000_1060: memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles. Expect burst_address=0x0000_1060, line_rdata={0x44..,0x33..,0x22..,0x11..}, line_resp exactly one cycle, 6 cycles after the request.
- Write line 0xDEAD..BEEF to 0x0000_207F: expect burst_address=0x0000_2060, beats presented in ascending order, each held until burst_resp. Inject 2 idle cycles between beats 1 and 2; expect line_resp one cycle after the 4th ack.
- Simultaneous line_read=line_write=1: write burst runs first, line_resp pulses, one IDLE cycle, then read burst. Two line_resp pulses total.
- Spurious burst_resp in IDLE, and line_read dropped after beat 1: cnt and line_rdata unchanged in IDLE; the burst still completes 4 beats.
- rst_n pulsed low during beat 2 of a read: burst_read drops in the same cycle and line_resp never fires. A subsequent read starts at beat 0 and returns the correct line.
- Parameter sweep s_burst=32 (8 beats) and 128 (2 beats): the read/write scenarios above pass, with latency num_bursts+2.
